// File: rtl/lock_code_enroll_if.sv
// Keypad-to-enrolment bus: start/digit stream in, code store outputs back.
// The master drives the keypad side and the slave is the enrolment block.
interface lock_code_enroll_if #(
  parameter int DW = 4,
  parameter int CW = 16
);
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [CW-1:0] code_out;
  logic          code_we;
  logic          done;
  logic          fail;
  logic          busy;
  logic          timeout;

  modport master (
    output start, data_in, data_valid,
    input  code_out, code_we, done,
    input  fail, busy, timeout
  );

  modport slave (
    input  start, data_in, data_valid,
    output code_out, code_we, done,
    output fail, busy, timeout
  );
endinterface

// File: rtl/lock_code_enroll.sv
// Digital lock code enrolment: enter, confirm, then commit to the code store.
// Optional idle abort when ENROLL_TIMEOUT_EN is defined.
module lock_code_enroll #(
  parameter int DIGITS      = 4,
  parameter int DW          = 4,
  parameter int MAX_TRIES   = 3,
  parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 16'h1101,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  lock_code_enroll_if.slave bus
);
  localparam int W    = DIGITS * DW;
  localparam int CNTW = $clog2(DIGITS + 1);
  localparam int TRW  = $clog2(MAX_TRIES + 1);

  if (MAX_TRIES < 1 || MAX_TRIES > 7 || TIMEOUT_CYC < 1 || DIGITS < 2)
  begin : g_bad_param
    $error("lock_code_enroll: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, ENTER, CONFIRM, COMMIT, DONE, LOCKOUT
  } state_t;

  state_t          state;
  logic [W-1:0]    ebuf;
  logic [CNTW-1:0] cnt;
  logic [TRW-1:0]  tries;
  logic            mis;
  logic [W-1:0]    code_q;
  logic            we_q;
  logic            done_q;
  logic            fail_q;
  logic            busy_q;

  logic [DW-1:0]   dig;
  logic            mis_now;
  logic            last;
  logic [TRW-1:0]  tries_nx;

  // Confirm digits are checked against the buffer MSB-first
  always_comb begin
    dig = '0;
    for (int i = 0; i < DIGITS; i++)
      if (cnt == CNTW'(i))
        dig = ebuf[W-1-i*DW -: DW];
  end

  assign mis_now  = mis | (bus.data_in != dig);
  assign last     = (cnt == CNTW'(DIGITS - 1));
  assign tries_nx = tries + TRW'(1);

`ifdef ENROLL_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] tcnt;
  logic           tmo_q;
  logic           waiting;
  assign waiting = (state == ENTER) || (state == CONFIRM);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ebuf   <= '0;
      cnt    <= '0;
      tries  <= '0;
      mis    <= 1'b0;
      code_q <= DEFAULT_CODE;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef ENROLL_TIMEOUT_EN
      tcnt   <= '0;
      tmo_q  <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ENTER;
            ebuf   <= '0;
            cnt    <= '0;
            mis    <= 1'b0;
            tries  <= '0;
            busy_q <= 1'b1;
          end
        end
        ENTER: begin
          if (bus.data_valid) begin
            ebuf <= {ebuf[W-DW-1:0], bus.data_in};
            if (last) begin
              state <= CONFIRM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        CONFIRM: begin
          if (bus.data_valid) begin
            if (!last) begin
              cnt <= cnt + CNTW'(1);
              mis <= mis_now;
            end else if (!mis_now) begin
              state  <= COMMIT;
              code_q <= ebuf;
              we_q   <= 1'b1;
            end else if (tries_nx == TRW'(MAX_TRIES)) begin
              state  <= LOCKOUT;
              tries  <= tries_nx;
              fail_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state <= ENTER;
              tries <= tries_nx;
              ebuf  <= '0;
              cnt   <= '0;
              mis   <= 1'b0;
            end
          end
        end
        COMMIT: begin
          state  <= DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        LOCKOUT: begin
          if (bus.start) begin
            state  <= ENTER;
            ebuf   <= '0;
            cnt    <= '0;
            mis    <= 1'b0;
            tries  <= '0;
            fail_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ENROLL_TIMEOUT_EN
      tmo_q <= 1'b0;
      // No case branch touches state in ENTER/CONFIRM without a digit
      if (waiting && !bus.data_valid) begin
        if (tcnt == TCW'(TIMEOUT_CYC - 1)) begin
          state  <= IDLE;
          tmo_q  <= 1'b1;
          ebuf   <= '0;
          cnt    <= '0;
          mis    <= 1'b0;
          busy_q <= 1'b0;
          tcnt   <= '0;
        end else begin
          tcnt <= tcnt + TCW'(1);
        end
      end else begin
        tcnt <= '0;
      end
`endif
    end
  end

  assign bus.code_out = code_q;
  assign bus.code_we  = we_q;
  assign bus.done     = done_q;
  assign bus.fail     = fail_q;
  assign bus.busy     = busy_q;
`ifdef ENROLL_TIMEOUT_EN
  assign bus.timeout  = tmo_q;
`else
  assign bus.timeout  = 1'b0;
`endif
endmodule
